// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for single-port RAM arbitration.
// Defaults here match ram_port_arbiter's default parameters.
package ram_arb_pkg;

    localparam int ARB_NREQ    = 4;
    localparam int ARB_WIDTHAD = 16;
    localparam int ARB_WIDTH   = 32;
    localparam int PTR_W       = $clog2(ARB_NREQ);

    typedef struct packed {
        logic                   we;
        logic [ARB_WIDTHAD-1:0] addr;
        logic [ARB_WIDTH-1:0]   wdata;
    } ram_req_t;

    // One-hot grant to the first valid requester at or above ptr, wrapping.
    function automatic logic [ARB_NREQ-1:0] rr_pick(input logic [ARB_NREQ-1:0] valid,
                                                    input logic [PTR_W-1:0]    ptr);
        logic [ARB_NREQ-1:0] grant;
        logic [PTR_W:0]      sum;
        logic                found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < ARB_NREQ; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(ARB_NREQ))
                sum = sum - (PTR_W+1)'(ARB_NREQ);
            if (!found && valid[sum[PTR_W-1:0]]) begin
                grant[sum[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Rotate-and-priority encoder: one-hot grant to the first valid index
// searching upward from ptr modulo N. Purely combinational.
module rr_pick_onehot #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    localparam logic [PW:0] N_W = (PW+1)'(N);

    logic [PW:0] sum;
    logic        found;

    // Wrap is an explicit subtract so non-power-of-two N never selects >= N.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= N_W)
                sum = sum - N_W;
            if (!found && valid[sum[PW-1:0]]) begin
                grant[sum[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters.
// Define RAM_ARB_LOCK_EN to enable per-requester grant locking via req_lock.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTHAD = 16,
    parameter int WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ*WIDTHAD-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_wdata,
    input  logic [NREQ-1:0]         req_lock,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_rdata,
    output logic [WIDTHAD-1:0]      ram_address,
    output logic                    ram_wren,
    output logic [WIDTH-1:0]        ram_data,
    output logic                    ram_rden,
    input  logic [WIDTH-1:0]        ram_q
);

    localparam int             PW   = $clog2(NREQ);
    localparam logic [PW-1:0]  LAST = PW'(NREQ - 1);

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      g_idx;
    logic [PW-1:0]      ptr_next;
    logic [NREQ-1:0]    arb_valid;
    logic [NREQ-1:0]    pick;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    rsp_owner;
    logic [WIDTHAD-1:0] addr_q;
    logic [WIDTH-1:0]   data_q;
    logic               granted;
    logic               we_g;
    logic               ptr_adv;

`ifdef RAM_ARB_LOCK_EN
    logic          lock_held;
    logic [PW-1:0] lock_owner;

    always_comb begin
        arb_valid = req_valid;
        if (lock_held) begin
            arb_valid             = '0;
            arb_valid[lock_owner] = req_valid[lock_owner];
        end
    end

    // Pointer stays put while a locked sequence is in progress.
    assign ptr_adv = granted & ~req_lock[g_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_held  <= 1'b0;
            lock_owner <= '0;
        end else if (lock_held && !req_valid[lock_owner]) begin
            lock_held <= 1'b0;
        end else if (granted) begin
            lock_held  <= req_lock[g_idx];
            lock_owner <= g_idx;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign arb_valid   = req_valid;
    assign ptr_adv     = granted;
`endif

    rr_pick_onehot #(.N(NREQ), .PW(PW)) u_pick (
        .valid (arb_valid),
        .ptr   (rr_ptr),
        .grant (pick)
    );

    // Gate the grant with reset so nothing reaches the RAM while rst_n is low.
    assign grant   = rst_n ? pick : '0;
    assign granted = |grant;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i])
                g_idx = PW'(i);
    end

    assign ptr_next = (g_idx == LAST) ? '0 : g_idx + 1'b1;
    assign we_g     = req_we[g_idx];

    assign req_ready   = grant;
    assign ram_address = granted ? req_addr[int'(g_idx)*WIDTHAD +: WIDTHAD] : addr_q;
    assign ram_data    = granted ? req_wdata[int'(g_idx)*WIDTH +: WIDTH] : data_q;
    assign ram_wren    = granted & we_g;
    assign ram_rden    = granted & ~we_g;
    assign rsp_valid   = rsp_owner;
    assign rsp_rdata   = ram_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            rsp_owner <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            rsp_owner <= grant & ~req_we;
            if (granted) begin
                addr_q <= ram_address;
                data_q <= ram_data;
            end
            if (ptr_adv)
                rr_ptr <= ptr_next;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter (4-requester instance plus a 3-requester
// instance), with a behavioural registered-address RAM on the 4-requester port.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]   req_valid = '0;
    logic [3:0]   req_we    = '0;
    logic [63:0]  req_addr  = '0;
    logic [127:0] req_wdata = '0;
    logic [3:0]   req_lock  = '0;
    logic [3:0]   req_ready, rsp_valid;
    logic [31:0]  rsp_rdata, ram_data, ram_q;
    logic [15:0]  ram_address;
    logic         ram_wren, ram_rden;

    logic [2:0]  v3 = '0;
    logic [2:0]  we3 = '0;
    logic [2:0]  lk3 = '0;
    logic [47:0] addr3 = '0;
    logic [95:0] wd3 = '0;
    logic [2:0]  ready3, rsp3;
    logic [31:0] rdata3, data_o3;
    logic [31:0] ram_q3 = '0;
    logic [15:0] addr_o3;
    logic        wren3, rden3;

    int n_chk  = 0;
    int n_pass = 0;

    ram_port_arbiter #(.NREQ(4), .WIDTHAD(16), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
        .ram_rden(ram_rden), .ram_q(ram_q)
    );

    ram_port_arbiter #(.NREQ(3), .WIDTHAD(16), .WIDTH(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_we(we3),
        .req_addr(addr3), .req_wdata(wd3), .req_lock(lk3),
        .req_ready(ready3), .rsp_valid(rsp3), .rsp_rdata(rdata3),
        .ram_address(addr_o3), .ram_wren(wren3), .ram_data(data_o3),
        .ram_rden(rden3), .ram_q(ram_q3)
    );

    // RAM: registered address, new data visible on the same port after a write.
    logic [31:0] mem [0:65535];
    logic [15:0] ram_addr_q = '0;
    logic        pre_done = 1'b0;

    always @(posedge clk) begin
        if (!pre_done) begin
            mem[16'h0010] <= 32'hDEADBEEF;
            for (int i = 0; i < 4; i++)
                mem[16'h0030 + 16'(i)] <= 32'h000000A0 + 32'(i);
            pre_done <= 1'b1;
        end
        if (ram_wren)
            mem[ram_address] <= ram_data;
        if (ram_wren | ram_rden)
            ram_addr_q <= ram_address;
    end
    assign ram_q = mem[ram_addr_q];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [15:0] a, input logic [31:0] d, input logic lk);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*16 +: 16]  = a;
        req_wdata[i*32 +: 32] = d;
        req_lock[i]           = lk;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_gnt [0:4];

    initial begin
        exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
        exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;

        // Reset gating with requests pending
        req_valid = 4'b1111;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'(4'b0000));
        check("rst_rden", 64'(ram_rden), 64'(1'b0));
        check("rst_rsp", 64'(rsp_valid), 64'(4'b0000));
        next_cycle();
        req_valid = '0;
        rst_n = 1'b1;

        // Single read by req 1
        set_req(1, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b0);
        @(negedge clk);
        check("rd_ready", 64'(req_ready), 64'(4'b0010));
        check("rd_rden", 64'(ram_rden), 64'(1'b1));
        check("rd_wren", 64'(ram_wren), 64'(1'b0));
        check("rd_addr", 64'(ram_address), 64'(16'h0010));
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("rd_rsp", 64'(rsp_valid), 64'(4'b0010));
        check("rd_data", 64'(rsp_rdata), 64'(32'hDEADBEEF));
        check("rd_ready_idle", 64'(req_ready), 64'(4'b0000));
        next_cycle();
        @(negedge clk);
        check("rd_rsp_once", 64'(rsp_valid), 64'(4'b0000));

        // All four requesters reading from reset
        next_cycle();
        do_reset();
        for (int i = 0; i < 4; i++)
            set_req(i, 1'b1, 1'b0, 16'h0030 + 16'(i), 32'h0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check($sformatf("rr_gnt%0d", j), 64'(req_ready), 64'(exp_gnt[j]));
            if (j == 0) begin
                check("rr_rsp0", 64'(rsp_valid), 64'(4'b0000));
            end else begin
                check($sformatf("rr_rsp%0d", j), 64'(rsp_valid), 64'(exp_gnt[j-1]));
                check($sformatf("rr_dat%0d", j), 64'(rsp_rdata), 64'(32'hA0 + 32'(j-1)));
            end
            next_cycle();
        end
        req_valid = '0;
        @(negedge clk);
        check("rr_rsp5", 64'(rsp_valid), 64'(4'b0001));
        check("rr_dat5", 64'(rsp_rdata), 64'(32'h000000A0));

        // Req 2: write then read same address
        next_cycle();
        set_req(2, 1'b1, 1'b1, 16'h0100, 32'h12345678, 1'b0);
        @(negedge clk);
        check("wr_ready", 64'(req_ready), 64'(4'b0100));
        check("wr_wren", 64'(ram_wren), 64'(1'b1));
        check("wr_data", 64'(ram_data), 64'(32'h12345678));
        next_cycle();
        req_we[2] = 1'b0;
        @(negedge clk);
        check("wr_rsp_none", 64'(rsp_valid), 64'(4'b0000));
        check("wrrd_ready", 64'(req_ready), 64'(4'b0100));
        check("wrrd_rden", 64'(ram_rden), 64'(1'b1));
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("wrrd_rsp", 64'(rsp_valid), 64'(4'b0100));
        check("wrrd_data", 64'(rsp_rdata), 64'(32'h12345678));

        // Reset the cycle after an accepted read by req 1
        next_cycle();
        set_req(1, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b0);
        @(negedge clk);
        check("mr_ready", 64'(req_ready), 64'(4'b0010));
        next_cycle();
        req_valid = 4'b1010;
        req_we    = 4'b0000;
        rst_n     = 1'b0;
        #1;
        check("mr_rsp", 64'(rsp_valid), 64'(4'b0000));
        check("mr_rden", 64'(ram_rden), 64'(1'b0));
        check("mr_wren", 64'(ram_wren), 64'(1'b0));
        check("mr_ready0", 64'(req_ready), 64'(4'b0000));
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_first", 64'(req_ready), 64'(4'b0010));

        // Lock: req 0 locked read while req 3 waits, then unlocking write
        next_cycle();
        req_valid = '0;
        do_reset();
        set_req(0, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b1);
        set_req(3, 1'b1, 1'b0, 16'h0031, 32'h0, 1'b0);
        @(negedge clk);
        check("lk_first", 64'(req_ready), 64'(4'b0001));
        next_cycle();
        set_req(0, 1'b1, 1'b1, 16'h0020, 32'h55AA55AA, 1'b0);
        @(negedge clk);
`ifdef RAM_ARB_LOCK_EN
        check("lk_hold", 64'(req_ready), 64'(4'b0001));
        check("lk_wren", 64'(ram_wren), 64'(1'b1));
`else
        check("lk_ignored", 64'(req_ready), 64'(4'b1000));
`endif
        next_cycle();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("lk_release", 64'(req_ready), 64'(4'b1000));
        next_cycle();
        req_valid = '0;
        req_lock  = '0;

        // Three-requester instance: 0 and 2 both valid
        do_reset();
        v3 = 3'b101;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("n3_gnt%0d", j), 64'(ready3), 64'((j % 2 == 0) ? 3'b001 : 3'b100));
            next_cycle();
        end
        v3 = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares one port of the on-chip dual-port RAM between NREQ requesters (e.g. core load/store, DMA, debug).
- Accepts at most one read or write per cycle, drives the RAM port directly, and routes read data back to the issuing requester one cycle later.
- Optional per-requester lock holds the grant across multi-cycle sequences (e.g. read-modify-write).

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTHAD, 16, RAM address width.
- WIDTH, 32, RAM data width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*WIDTHAD  packed addresses; requester i at [i*WIDTHAD +: WIDTHAD].
- req_wdata  in  NREQ*WIDTH  packed write data, same packing.
- req_lock  in  NREQ  hold grant after this access (compiled only with RAM_ARB_LOCK_EN).
- req_ready  out  NREQ  one-hot grant; a request is accepted when valid & ready.
- rsp_valid  out  NREQ  one-hot; read data valid for requester i.
- rsp_rdata  out  WIDTH  read data, shared by all requesters.
- ram_address  out  WIDTHAD  to RAM port address.
- ram_wren  out  1  to RAM port write enable.
- ram_data  out  WIDTH  to RAM port write data.
- ram_rden  out  1  to RAM port read enable.
- ram_q  in  WIDTH  from RAM port; unregistered output of a registered address.

Behaviour:
- Reset values: rr_ptr = 0, rsp_valid = 0, lock_owner invalid. While rst_n is low, ram_wren = 0, ram_rden = 0 and req_ready = 0 (all combinationally gated).
- Arbitration (combinational, same cycle):
  - Grant goes to the first requester with req_valid set, searching from rr_ptr upward modulo NREQ.
  - req_ready is one-hot to the granted requester, or all zero if no request is pending.
  - Requesters may hold valid with addr/we/wdata stable until ready. The arbiter does not require valid to remain asserted.
- RAM drive:
  - ram_address and ram_data are muxed from the granted requester.
  - ram_wren = granted & we; ram_rden = granted & ~we.
  - With no grant, outputs hold the previous address, wren = 0, rden = 0.
- Pointer update: on an accepted access by requester g, rr_ptr <= (g+1) mod NREQ. With no accept, rr_ptr holds.
- Read latency:
  - A read accepted in cycle k gives rsp_valid[g] = 1 in cycle k+1 for exactly one cycle.
  - rsp_rdata = ram_q combinationally during that cycle. rsp_rdata is don't-care when rsp_valid = 0.
  - Response tag register is rsp_owner[NREQ-1:0] <= grant & ~we.
- Throughput: one access per cycle. Back-to-back reads from different requesters yield back-to-back one-hot rsp_valid.
- Write then read, same address, consecutive cycles: the read returns the new data (RAM port is new-data-on-same-port).
- Writes produce no response.
- Fairness: a requester holding valid is granted within NREQ accepted accesses (no lock) or after the lock is released.
- Reset mid-operation: a pending response is dropped (rsp_valid = 0 from reset assertion), the pointer returns to 0, and any lock is cleared.
- NREQ not a power of two: pointer wraps from NREQ-1 to 0 explicitly; no out-of-range index is ever granted.

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- Defined:
  - If the granted requester has req_lock = 1 on an accepted access, lock_owner <= g.
  - While a lock is held, only lock_owner can be granted; other requests stall.
  - Lock releases on an accepted access with req_lock = 0, or when lock_owner deasserts req_valid for one cycle.
  - rr_ptr updates only on the releasing access.
- Undefined: the req_lock port is still present but ignored; pure round-robin.

Decomposition:
- Package ram_arb_pkg holds:
  - ram_req_t, a struct of we/addr/wdata parameterised by localparams matching defaults;
  - function rr_pick(valid, ptr), returning a one-hot grant;
  - localparam PTR_W = $clog2(NREQ).
- One sub-module, rr_pick_onehot: combinational rotate-and-priority encoder, reused by other arbiters.

Test Plan:
- Single read: RAM preloaded with 0xDEADBEEF at address 0x0010; req 1 reads 0x0010 -> req_ready = 4'b0010 in cycle k, ram_rden = 1 and ram_address = 0x0010 in cycle k; rsp_valid = 4'b0010 and rsp_rdata = 0xDEADBEEF in cycle k+1.
- All four requesters hold valid reads from reset -> grants in order 0, 1, 2, 3, 0; rsp_valid one-hot in the same order, each one cycle delayed.
- Req 2 writes 0x12345678 to 0x0100 in cycle k, then reads 0x0100 in cycle k+1 -> rsp_valid[2] in cycle k+2 with 0x12345678; no rsp_valid for the write.
- Lock (RAM_ARB_LOCK_EN):
  - Req 0 reads 0x20 with lock while req 3 holds valid -> req 3 gets no grant.
  - Req 0 then writes 0x20 with lock = 0 -> req 3 is granted on the next cycle.
- Reset mid-read: assert rst_n = 0 the cycle after a read is accepted -> rsp_valid = 0 and ram_wren/ram_rden = 0 immediately; after release, first grant goes to the lowest valid index from 0.
- NREQ = 3 build: requesters 0 and 2 continuously valid -> grants alternate 0, 2, 0, 2; pointer never selects index 3.
